// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter_if
//  Description : Two-requester plus data-memory bus bundle for dmem_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          req0;
    logic          we0;
    logic          lock0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          gnt0;
    logic          rvalid0;
    logic [DW-1:0] rdata0;

    logic          req1;
    logic          we1;
    logic          lock1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          gnt1;
    logic          rvalid1;
    logic [DW-1:0] rdata1;

    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_writeData;
    logic          mem_writeEnable;
    logic [DW-1:0] mem_readData;

    // Arbiter view: requests in, grants/read data out, drives the memory.
    modport slave (
        input  req0, we0, lock0, addr0, wdata0,
        output gnt0, rvalid0, rdata0,
        input  req1, we1, lock1, addr1, wdata1,
        output gnt1, rvalid1, rdata1,
        output mem_address, mem_writeData, mem_writeEnable,
        input  mem_readData
    );

    modport master (
        output req0, we0, lock0, addr0, wdata0,
        input  gnt0, rvalid0, rdata0,
        output req1, we1, lock1, addr1, wdata1,
        input  gnt1, rvalid1, rdata1,
        input  mem_address, mem_writeData, mem_writeEnable,
        output mem_readData
    );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Round-robin two-port arbiter with lock for a shared data memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input wire logic      clk,
    input wire logic      rst_n,
    dmem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        LOCK_NONE = 2'd0,
        LOCK_P0   = 2'd1,
        LOCK_P1   = 2'd2
    } lock_t;

    lock_t         r_lock;
    lock_t         w_lock_nxt;
    logic          r_ptr;
    logic          w_ptr_nxt;
    logic          w_win0;
    logic          w_win1;

    logic          r_cmd_valid;
    logic          r_cmd_we;
    logic          r_cmd_port;
    logic [AW-1:0] r_cmd_addr;
    logic [DW-1:0] r_cmd_wdata;

    logic          r_rvalid0;
    logic          r_rvalid1;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;

    logic          w_rd_ret0;
    logic          w_rd_ret1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lock <= LOCK_NONE;
            r_ptr  <= 1'b0;
        end else begin
            r_lock <= w_lock_nxt;
            r_ptr  <= w_ptr_nxt;
        end
    end

    // Winner selection plus lock-owner / priority-pointer next state.
    always_comb begin
        w_win0     = 1'b0;
        w_win1     = 1'b0;
        w_lock_nxt = r_lock;
        w_ptr_nxt  = r_ptr;

        case (r_lock)
            LOCK_P0: w_win0 = bus.req0;
            LOCK_P1: w_win1 = bus.req1;
            default: begin
                if (bus.req0 && bus.req1) begin
                    w_win0 = ~r_ptr;
                    w_win1 = r_ptr;
                end else begin
                    w_win0 = bus.req0;
                    w_win1 = bus.req1;
                end
            end
        endcase

        if (!rst_n) begin
            w_win0 = 1'b0;
            w_win1 = 1'b0;
        end

        case (r_lock)
            LOCK_NONE: begin
                // The loser of this cycle gets priority next time.
                if (w_win0 || w_win1)
                    w_ptr_nxt = w_win0;
                if (w_win0 && bus.lock0)
                    w_lock_nxt = LOCK_P0;
                else if (w_win1 && bus.lock1)
                    w_lock_nxt = LOCK_P1;
            end
            LOCK_P0: begin
                if (!bus.lock0 && (w_win0 || !bus.req0))
                    w_lock_nxt = LOCK_NONE;
            end
            LOCK_P1: begin
                if (!bus.lock1 && (w_win1 || !bus.req1))
                    w_lock_nxt = LOCK_NONE;
            end
            default: w_lock_nxt = LOCK_NONE;
        endcase
    end

    assign w_rd_ret0 = r_cmd_valid && !r_cmd_we && !r_cmd_port;
    assign w_rd_ret1 = r_cmd_valid && !r_cmd_we &&  r_cmd_port;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cmd_valid <= 1'b0;
            r_cmd_we    <= 1'b0;
            r_cmd_port  <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_wdata <= '0;
            r_rvalid0   <= 1'b0;
            r_rvalid1   <= 1'b0;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
        end else begin
            r_cmd_valid <= w_win0 | w_win1;
            // Address/data only reload on a grant so the memory bus holds when idle.
            if (w_win0 || w_win1) begin
                r_cmd_port  <= w_win1;
                r_cmd_we    <= w_win1 ? bus.we1    : bus.we0;
                r_cmd_addr  <= w_win1 ? bus.addr1  : bus.addr0;
                r_cmd_wdata <= w_win1 ? bus.wdata1 : bus.wdata0;
            end
            r_rvalid0 <= w_rd_ret0;
            r_rvalid1 <= w_rd_ret1;
            if (w_rd_ret0)
                r_rdata0 <= bus.mem_readData;
            if (w_rd_ret1)
                r_rdata1 <= bus.mem_readData;
        end
    end

    assign bus.gnt0    = w_win0;
    assign bus.gnt1    = w_win1;
    assign bus.rvalid0 = r_rvalid0;
    assign bus.rvalid1 = r_rvalid1;
    assign bus.rdata0  = r_rdata0;
    assign bus.rdata1  = r_rdata1;

    // Gating with rst_n drops a write still in flight when reset arrives.
    assign bus.mem_address     = r_cmd_addr;
    assign bus.mem_writeData   = r_cmd_wdata;
    assign bus.mem_writeEnable = r_cmd_valid & r_cmd_we & rst_n;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Directed self-checking bench for dmem_arbiter with a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    logic clk;
    logic rst_n;
    bit   model_on;
    int   n_checks;
    int   n_errors;

    logic [7:0] mem    [256];
    logic [7:0] shadow [256];

    dmem_arbiter_if #(.AW(8), .DW(8)) bus ();

    dmem_arbiter #(.AW(8), .DW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory with combinational read.
    assign bus.mem_readData = mem[bus.mem_address];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        forever begin
            @(posedge clk);
            if (bus.mem_writeEnable) mem[bus.mem_address] <= bus.mem_writeData;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Reference model: grants from the arbitration rules, a one-slot command
    // stage, a read-return slot per port and a shadow of memory contents.
    initial begin : model
        int         owner;
        int         ptr;
        int         win;
        logic       g0, g1;
        logic       b_valid, b_we, b_port;
        logic [7:0] b_addr, b_data;
        logic [7:0] last_addr, last_data;
        logic       rv0, rv1;
        logic [7:0] rd0, rd1;

        for (int i = 0; i < 256; i++) shadow[i] = 8'(i);
        owner = -1; ptr = 0;
        b_valid = 0; b_we = 0; b_port = 0; b_addr = 0; b_data = 0;
        last_addr = 0; last_data = 0;
        rv0 = 0; rv1 = 0; rd0 = 0; rd1 = 0;

        forever begin
            @(negedge clk);
            if (model_on) begin
                g0 = 0; g1 = 0;
                if (rst_n) begin
                    if (owner == 0)      g0 = bus.req0;
                    else if (owner == 1) g1 = bus.req1;
                    else if (bus.req0 && bus.req1) begin
                        if (ptr == 0) g0 = 1; else g1 = 1;
                    end else begin
                        g0 = bus.req0; g1 = bus.req1;
                    end
                end

                check("m_gnt0", bus.gnt0, g0);
                check("m_gnt1", bus.gnt1, g1);
                check("m_mem_we", bus.mem_writeEnable, b_valid && b_we && rst_n);
                check("m_mem_addr", bus.mem_address, last_addr);
                check("m_mem_wdata", bus.mem_writeData, last_data);
                check("m_rvalid0", bus.rvalid0, rv0);
                check("m_rvalid1", bus.rvalid1, rv1);
                check("m_rdata0", bus.rdata0, rd0);
                check("m_rdata1", bus.rdata1, rd1);

                if (!rst_n) begin
                    owner = -1; ptr = 0; b_valid = 0; b_we = 0;
                    last_addr = 0; last_data = 0;
                    rv0 = 0; rv1 = 0; rd0 = 0; rd1 = 0;
                end else begin
                    rv0 = 0; rv1 = 0;
                    if (b_valid) begin
                        if (b_we) shadow[b_addr] = b_data;
                        else if (b_port) begin rv1 = 1; rd1 = shadow[b_addr]; end
                        else begin rv0 = 1; rd0 = shadow[b_addr]; end
                    end
                    b_valid = g0 || g1;
                    if (b_valid) begin
                        win = g1 ? 1 : 0;
                        b_port = g1;
                        b_we   = g1 ? bus.we1 : bus.we0;
                        b_addr = g1 ? bus.addr1 : bus.addr0;
                        b_data = g1 ? bus.wdata1 : bus.wdata0;
                        last_addr = b_addr;
                        last_data = b_data;
                        if (owner == -1) begin
                            ptr = 1 - win;
                            if ((win == 0 && bus.lock0) || (win == 1 && bus.lock1)) owner = win;
                        end
                    end
                    if (owner == 0 && !bus.lock0 && (g0 || !bus.req0)) owner = -1;
                    else if (owner == 1 && !bus.lock1 && (g1 || !bus.req1)) owner = -1;
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0; n_errors = 0; model_on = 0;
        rst_n = 1'b0;
        bus.req0 = 1; bus.we0 = 0; bus.lock0 = 0; bus.addr0 = 8'h01; bus.wdata0 = 0;
        bus.req1 = 1; bus.we1 = 0; bus.lock1 = 0; bus.addr1 = 8'h02; bus.wdata1 = 0;

        // Reset with both ports requesting.
        repeat (2) @(posedge clk);
        #1;
        model_on = 1;
        check("rst_gnt0", bus.gnt0, 0);
        check("rst_gnt1", bus.gnt1, 0);
        check("rst_rvalid0", bus.rvalid0, 0);
        check("rst_rdata1", bus.rdata1, 0);
        check("rst_mem_we", bus.mem_writeEnable, 0);
        check("rst_mem_addr", bus.mem_address, 0);
        step;

        // Contention: grants alternate starting with port 0.
        rst_n = 1'b1; #1;
        check("cont_c0_gnt0", bus.gnt0, 1);
        check("cont_c0_gnt1", bus.gnt1, 0);
        step;
        check("cont_c1_gnt1", bus.gnt1, 1);
        step;
        check("cont_c2_gnt0", bus.gnt0, 1);
        check("cont_c2_rvalid0", bus.rvalid0, 1);
        check("cont_c2_rdata0", bus.rdata0, 8'h01);
        step;
        check("cont_c3_gnt1", bus.gnt1, 1);
        check("cont_c3_rvalid1", bus.rvalid1, 1);
        check("cont_c3_rdata1", bus.rdata1, 8'h02);
        bus.req0 = 0; bus.req1 = 0;
        step; step;

        // Single write then read on port 0.
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = 8'h10; bus.wdata0 = 8'hA5; #1;
        check("wr_gnt0", bus.gnt0, 1);
        step;
        check("wr_mem_we", bus.mem_writeEnable, 1);
        check("wr_mem_addr", bus.mem_address, 8'h10);
        check("wr_mem_data", bus.mem_writeData, 8'hA5);
        bus.we0 = 0; #1;
        check("rd_gnt0", bus.gnt0, 1);
        step;
        bus.req0 = 0;
        step;
        check("rd_rvalid0", bus.rvalid0, 1);
        check("rd_rdata0", bus.rdata0, 8'hA5);
        step;
        check("rd_rvalid0_pulse", bus.rvalid0, 0);
        check("rd_rdata0_hold", bus.rdata0, 8'hA5);

        // Lock: port 1 keeps port 0 out for three grants.
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 8'h05;
        bus.req1 = 1; bus.we1 = 0; bus.lock1 = 1; bus.addr1 = 8'h20; #1;
        check("lk_a_gnt1", bus.gnt1, 1);
        check("lk_a_gnt0", bus.gnt0, 0);
        step;
        bus.we1 = 1; bus.addr1 = 8'h21; bus.wdata1 = 8'h77; #1;
        check("lk_b_gnt1", bus.gnt1, 1);
        check("lk_b_gnt0", bus.gnt0, 0);
        step;
        bus.addr1 = 8'h22; bus.wdata1 = 8'h88; bus.lock1 = 0; #1;
        check("lk_c_gnt1", bus.gnt1, 1);
        check("lk_c_gnt0", bus.gnt0, 0);
        check("lk_c_rdata1", bus.rdata1, 8'h20);
        step;
        bus.req1 = 0; #1;
        check("lk_d_gnt0", bus.gnt0, 1);
        step;
        bus.req0 = 0;
        step; step;
        check("lk_mem21", mem[8'h21], 8'h77);

        // Lock released by an idle owner.
        bus.req0 = 1; bus.lock0 = 1; bus.addr0 = 8'h30; #1;
        check("lr_gnt0", bus.gnt0, 1);
        step;
        bus.req0 = 0; bus.lock0 = 0;
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = 8'h31; #1;
        check("lr_wait_gnt1", bus.gnt1, 0);
        step;
        check("lr_gnt1", bus.gnt1, 1);
        step;
        bus.req1 = 0;
        step; step;

        // Write followed immediately by a read of the same address.
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = 8'h40; bus.wdata0 = 8'h3C; #1;
        check("hz_gnt0", bus.gnt0, 1);
        step;
        bus.req0 = 0; bus.req1 = 1; bus.we1 = 0; bus.addr1 = 8'h40; #1;
        check("hz_gnt1", bus.gnt1, 1);
        step;
        bus.req1 = 0;
        step;
        check("hz_rvalid1", bus.rvalid1, 1);
        check("hz_rdata1", bus.rdata1, 8'h3C);
        step;

        // Reset while a write is in the command stage.
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = 8'h50; bus.wdata0 = 8'hFF; #1;
        check("mr_gnt0", bus.gnt0, 1);
        step;
        bus.req0 = 0; rst_n = 1'b0; #1;
        check("mr_mem_we", bus.mem_writeEnable, 0);
        step;
        rst_n = 1'b1;
        check("mr_rvalid0", bus.rvalid0, 0);
        step;
        check("mr_rvalid0_b", bus.rvalid0, 0);
        check("mr_rvalid1", bus.rvalid1, 0);
        check("mr_mem50", mem[8'h50], 8'h50);
        check("mr_rdata0", bus.rdata0, 0);
        step; step;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
